icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipeline CPU's fetch port (IM_en / IM_address / IM_out) and a slower word-wide backing instruction memory.
- Hits return the instruction combinationally in the same cycle, like the existing IM model.
- Misses assert IM_stall and run a multi-beat line fill over a req/ack handshake.
- The CPU gains an IM_stall input that freezes PC and the IF/ID register.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_store.sv | 70 +++++++
 rtl/icache_dm.sv | 173 +++++++++++++++++
 tb/tb_icache_dm.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   icache_state_e : fill controller states
//   NOP_OUT        : value driven on IM_out when no instruction is delivered
//   off_bits/idx_bits/tag_bits : address field widths from the geometry
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } icache_state_e;

    localparam logic [31:0] NOP_OUT = 32'h0;

    // Word-offset field width (word within a line).
    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width.
    function automatic int unsigned idx_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag width: everything above index and offset, below the byte bits.
    function automatic int unsigned tag_bits(input int unsigned lines,
                                             input int unsigned line_words);
        return 30 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_store.sv
// Register-based storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst                   clock, synchronous active-high reset (valid bits only)
//   rd_idx, rd_off             combinational lookup address
//   rd_valid, rd_tag, rd_word  lookup results
//   wr_en, wr_idx, wr_off, wr_data            single-word write (line fill beat)
//   commit_en, commit_idx, commit_tag, commit_valid  tag/valid update of one line
//   inval_all                  clear every valid bit
// Tag and data arrays carry no reset; only the valid bits are cleared.
module icache_store #(
    parameter int unsigned LINES      = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned OFF_W      = 2,
    parameter int unsigned TAG_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_word,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [31:0]       wr_data,
    input  logic              commit_en,
    input  logic [IDX_W-1:0]  commit_idx,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              commit_valid,
    input  logic              inval_all
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][LINE_WORDS];

    // A commit in the same cycle as inval_all wins for its own line, so a
    // line finishing its fill can be left valid or invalid explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (inval_all) begin
                valid_q <= '0;
            end
            if (commit_en) begin
                valid_q[commit_idx] <= commit_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit_en) begin
            tag_q[commit_idx] <= commit_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache in front of a word-wide backing
// memory. Hits are answered combinationally; a miss stalls the fetch port and
// fills the whole line over a req/ack handshake, one word per ack.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   IM_en           fetch request valid
//   IM_address      fetch byte address (bits [1:0] ignored)
//   IM_out          instruction, NOP_OUT when stalled or idle
//   IM_stall        fetch not satisfied this cycle
//   flush           invalidate all lines
//   mem_req         backing-memory read request (held until mem_ack)
//   mem_addr        word-aligned backing-memory address
//   mem_ack         one-cycle strobe, mem_rdata valid for current beat
//   mem_rdata       backing-memory read data
//   miss_cnt        misses since reset (wraps)
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_en,
    input  logic [31:0] IM_address,
    output logic [31:0] IM_out,
    output logic        IM_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] miss_cnt
);

    localparam int unsigned OFF_W  = off_bits(LINE_WORDS);
    localparam int unsigned IDX_W  = idx_bits(LINES);
    localparam int unsigned TAG_W  = tag_bits(LINES, LINE_WORDS);
    localparam int unsigned LINE_W = IDX_W + TAG_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    // Fetch address split.
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       unused_byte_bits;

    assign req_off          = IM_address[OFF_W+1:2];
    assign req_idx          = IM_address[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag          = IM_address[31:OFF_W+IDX_W+2];
    assign unused_byte_bits = IM_address[1:0];

    icache_state_e    state;
    logic [LINE_W-1:0] fill_line;   // {tag, idx} of the line being filled
    logic [OFF_W-1:0]  beat;
    logic              flush_pend;

    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LINE_W-1:IDX_W];

    // Storage interface.
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_word;
    logic             wr_en;
    logic             commit_en;
    logic             commit_valid;
    logic             inval_all;
    logic             hit;

    icache_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (req_idx),
        .rd_off       (req_off),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_word      (rd_word),
        .wr_en        (wr_en),
        .wr_idx       (fill_idx),
        .wr_off       (beat),
        .wr_data      (mem_rdata),
        .commit_en    (commit_en),
        .commit_idx   (fill_idx),
        .commit_tag   (fill_tag),
        .commit_valid (commit_valid),
        .inval_all    (inval_all)
    );

    // mem_req is only ever high in FILL, so gating the ack on the state is
    // what makes a stray ack outside a request harmless.
    assign wr_en        = (state == FILL) && mem_ack;
    assign commit_en    = (state == DONE);
    assign commit_valid = !(flush || flush_pend);

    // A flush seen during FILL is deferred to DONE; no lookup happens in
    // between, so clearing late is indistinguishable from clearing early.
    assign inval_all = ((state == IDLE) && flush) ||
                       ((state == DONE) && (flush || flush_pend));

    always_comb begin
        hit      = IM_en && rd_valid && (rd_tag == req_tag);
        IM_stall = 1'b1;
        IM_out   = NOP_OUT;
        case (state)
            IDLE: begin
                IM_stall = IM_en && !hit;
                if (hit) begin
                    IM_out = rd_word;
                end
            end
            default: begin
                IM_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            beat       <= '0;
            miss_cnt   <= '0;
            flush_pend <= 1'b0;
            fill_line  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IM_en && !hit) begin
                        fill_line <= {req_tag, req_idx};
                        mem_addr  <= {req_tag, req_idx, {(OFF_W + 2){1'b0}}};
                        mem_req   <= 1'b1;
                        beat      <= '0;
                        miss_cnt  <= miss_cnt + 32'd1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            mem_req <= 1'b0;
                            state   <= DONE;
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                DONE: begin
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm (LINES=16, LINE_WORDS=4).
// The driver pushes the expected response of each fetch into a queue using a
// line-level cache model; a monitor pops it whenever the DUT delivers an
// instruction. A memory responder returns address ^ KEY with wait states.
module tb_icache_dm;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IM_en = 1'b0;
    logic [31:0] IM_address = '0;
    logic [31:0] IM_out;
    logic        IM_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] miss_cnt;

    logic flush_drv = 1'b0;
    logic flush_resp = 1'b0;
    assign flush = flush_drv | flush_resp;

    always #5 clk = ~clk;

    icache_dm #(
        .LINES      (16),
        .LINE_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .IM_en      (IM_en),
        .IM_address (IM_address),
        .IM_out     (IM_out),
        .IM_stall   (IM_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .miss_cnt   (miss_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned stalls;
        logic [31:0] misses;
        int unsigned acks;
    } exp_t;

    exp_t exp_q[$];

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Line-level reference model: which memory line each slot holds.
    bit          model_valid[16];
    logic [27:0] model_line[16];
    logic [31:0] model_miss = '0;

    // Shared stimulus knobs read by the responder.
    int unsigned wait_states = 0;
    bit          flush_arm   = 1'b0;
    int unsigned flush_beat  = 0;
    logic [31:0] cur_addr    = '0;
    bit          mon_off     = 1'b1;
    int unsigned acks_total  = 0;
    int unsigned resp_beat   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            model_valid[i] = 1'b0;
        end
    endtask

    // Backing memory: acks each beat after wait_states idle cycles, optionally
    // raises flush together with the ack of a chosen beat, and throws stray
    // acks while no request is pending.
    initial begin
        int unsigned wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack    = 1'b0;
            flush_resp = 1'b0;
            if (rst || !mem_req) begin
                wait_cnt  = 0;
                resp_beat = 0;
                if (!rst && $urandom_range(0, 3) == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
            end else begin
                check("mem_addr", mem_addr, (cur_addr & ~32'hF) + 32'(4 * resp_beat));
                if (wait_cnt >= wait_states) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ KEY;
                    if (flush_arm && resp_beat == flush_beat) begin
                        flush_resp = 1'b1;
                        flush_arm  = 1'b0;
                    end
                    resp_beat++;
                    wait_cnt = 0;
                    acks_total++;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: pops an expectation every time a fetch is delivered.
    initial begin
        int unsigned stall_run;
        int unsigned last_acks;
        exp_t e;
        stall_run = 0;
        last_acks = 0;
        forever begin
            @(negedge clk);
            if (mon_off || rst) begin
                stall_run = 0;
                last_acks = acks_total;
            end else if (!IM_en) begin
                check("idle_stall", {31'b0, IM_stall}, 32'd0);
                check("idle_out", IM_out, 32'd0);
                check("idle_req", {31'b0, mem_req}, 32'd0);
            end else if (IM_stall) begin
                stall_run++;
                check("stalled_out", IM_out, 32'd0);
            end else begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_delivery: got %h expected none", IM_out);
                end else begin
                    e = exp_q.pop_front();
                    check("IM_out", IM_out, e.data);
                    check("stall_cycles", 32'(stall_run), 32'(e.stalls));
                    check("miss_cnt", miss_cnt, e.misses);
                    check("acks", 32'(acks_total - last_acks), 32'(e.acks));
                end
                stall_run = 0;
                last_acks = acks_total;
            end
        end
    end

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    // fb >= 0 raises flush during the ack of that beat of the miss fill.
    task automatic fetch(input logic [31:0] a, input bit fl_now, input int unsigned w, input int fb);
        exp_t        e;
        int unsigned idx;
        logic [27:0] ln;
        bit          hit;
        bit          done;
        int unsigned n;
        idx = int'(a[7:4]);
        ln  = a[31:4];
        hit = model_valid[idx] && (model_line[idx] == ln);
        if (fl_now) clear_model();
        e.addr = a;
        e.data = {a[31:2], 2'b00} ^ KEY;
        if (hit) begin
            e.stalls = 0;
            e.acks   = 0;
        end else begin
            if (fb >= 0) begin
                model_miss = model_miss + 32'd2;
                e.stalls   = 2 * (4 * w + 6);
                e.acks     = 8;
                clear_model();
            end else begin
                model_miss = model_miss + 32'd1;
                e.stalls   = 4 * w + 6;
                e.acks     = 4;
            end
            model_valid[idx] = 1'b1;
            model_line[idx]  = ln;
        end
        e.misses = model_miss;
        exp_q.push_back(e);

        wait_states = w;
        flush_arm   = !hit && (fb >= 0);
        flush_beat  = (fb >= 0) ? int'(fb) : 0;
        cur_addr    = a;
        IM_en       = 1'b1;
        IM_address  = a;
        flush_drv   = fl_now;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = !IM_stall;
            n++;
            @(posedge clk);
            #1;
            flush_drv = 1'b0;
            if (!done && n > 400) begin
                compared++;
                mismatched++;
                $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", a, n);
                finish_run();
            end
        end
    endtask

    task automatic idle(input bit fl);
        IM_en     = 1'b0;
        flush_drv = fl;
        if (fl) clear_model();
        @(posedge clk);
        #1;
        flush_drv = 1'b0;
    endtask

    logic [23:0] tag_pool[4];

    initial begin
        int unsigned n;
        logic [31:0] a;
        tag_pool[0] = 24'h000000;
        tag_pool[1] = 24'h000001;
        tag_pool[2] = 24'hABCDE0;
        tag_pool[3] = 24'hFFFFFF;
        clear_model();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'b0, IM_stall}, 32'd0);
        check("rst_out", IM_out, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        mon_off = 1'b0;

        // Cold miss, hits in the same line, conflict eviction.
        fetch(32'h0000_0000, 1'b0, 0, -1);
        fetch(32'h0000_0004, 1'b0, 0, -1);
        fetch(32'h0000_0008, 1'b0, 0, -1);
        fetch(32'h0000_000C, 1'b0, 0, -1);
        fetch(32'h0000_0100, 1'b0, 0, -1);
        fetch(32'h0000_0000, 1'b0, 0, -1);
        // Wait states.
        fetch(32'h0000_0040, 1'b0, 3, -1);
        // Flush in IDLE on a hit cycle: still a hit, then a miss.
        fetch(32'h0000_0000, 1'b1, 0, -1);
        fetch(32'h0000_0000, 1'b0, 0, -1);
        // Flush during beat 2 of a fill: refill on the same address.
        fetch(32'h0000_0200, 1'b0, 0, 2);
        fetch(32'h0000_0204, 1'b0, 0, -1);
        idle(1'b0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle(bit'($urandom_range(0, 1)));
            end else begin
                a = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)), 2'b00};
                if ($urandom_range(0, 9) == 0) begin
                    fetch(a, 1'b0, $urandom_range(0, 2), int'($urandom_range(0, 3)));
                end else begin
                    fetch(a, bit'($urandom_range(0, 15) == 0), $urandom_range(0, 2), -1);
                end
            end
        end

        // Reset in the middle of a fill.
        idle(1'b0);
        mon_off     = 1'b1;
        wait_states = 0;
        flush_arm   = 1'b0;
        cur_addr    = 32'h0000_0300;
        IM_address  = 32'h0000_0300;
        IM_en       = 1'b1;
        n = 0;
        while (resp_beat != 3 && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (resp_beat != 3) begin
            compared++;
            mismatched++;
            $display("FAIL reset_fill_wait: beat %0d expected 3", resp_beat);
        end
        rst   = 1'b1;
        IM_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midfill_rst_req", {31'b0, mem_req}, 32'd0);
        check("midfill_rst_stall", {31'b0, IM_stall}, 32'd0);
        check("midfill_rst_miss_cnt", miss_cnt, 32'd0);
        check("midfill_rst_out", IM_out, 32'd0);
        @(posedge clk);
        #1;
        clear_model();
        model_miss = '0;
        mon_off    = 1'b0;
        fetch(32'h0000_0000, 1'b0, 0, -1);
        idle(1'b0);
        idle(1'b0);

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
        end
        finish_run();
    end

endmodule
